// File: rtl/fat32_write_sequencer.sv
// fat32_write_sequencer: drives one SD sector port through BPB read, geometry check, data streaming and directory rewrites.
module fat32_write_sequencer #(
    parameter int DIR_UPDATE_INTERVAL = 16,
    parameter int MAX_SECTORS = 4194304,
    parameter int BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_ready,
    output logic        rd_start,
    output logic [31:0] rd_sector,
    input  logic        rd_done,
    input  logic        rd_en,
    input  logic [8:0]  rd_addr,
    input  logic [7:0]  rd_byte,
    output logic        wr_start,
    output logic [31:0] wr_sector,
    output logic        wr_src,
    input  logic        wr_done,
    input  logic [10:0] fifo_count,
    input  logic        flush,
    output logic [31:0] file_first_cluster,
    output logic [31:0] file_length,
    output logic [2:0]  state_o,
    output logic        error
);
    typedef enum logic [2:0] {S_IDLE, S_READ_BPB, S_CALC, S_WAIT, S_DATA, S_DIR, S_FULL, S_ERROR} state_t;
    state_t state, next;
    logic cmd_sent, flush_pend, bpb_ok, busy, done, data_done, dir_done;
    logic [15:0] bps, rsvd, sig;
    logic [7:0] spc, num_fats;
    logic [31:0] fat_len, root, data_base, data_count, since_dir, root_calc;
    logic [39:0] fat_span;
    assign fat_span = {32'b0, num_fats} * {8'b0, fat_len};
    assign root_calc = {16'b0, rsvd} + fat_span[31:0];
    assign bpb_ok = sig == 16'hAA55 && bps == 16'd512 && spc != 8'd0 && num_fats != 8'd0;
    assign busy = state == S_READ_BPB || state == S_DATA || state == S_DIR;
    // a done only counts once its command has actually been issued
    assign done = cmd_sent && (state == S_READ_BPB ? rd_done : wr_done);
    assign data_done = done && state == S_DATA;
    assign dir_done = done && state == S_DIR;
    assign rd_start = state == S_READ_BPB && !cmd_sent;
    assign rd_sector = '0;
    assign wr_start = (state == S_DATA || state == S_DIR) && !cmd_sent;
    assign wr_src = state == S_DIR;
    assign wr_sector = wr_src ? root : data_base + data_count;
    assign file_first_cluster = 32'd3;
    assign state_o = state;
    assign error = state == S_ERROR;
    always_comb begin
        next = state;
        case (state)
            S_IDLE:     next = card_ready ? S_READ_BPB : S_IDLE;
            S_READ_BPB: next = done ? S_CALC : S_READ_BPB;
            S_CALC:     next = bpb_ok ? S_WAIT : S_ERROR;
            S_WAIT:     next = (flush_pend || since_dir >= 32'(DIR_UPDATE_INTERVAL)) ? S_DIR :
                               (data_count == 32'(MAX_SECTORS)) ? S_FULL :
                               ({21'b0, fifo_count} >= 32'(BLOCK_BYTES)) ? S_DATA : S_WAIT;
            S_DATA:     next = done ? S_WAIT : S_DATA;
            S_DIR:      next = done ? S_WAIT : S_DIR;
            S_FULL:     next = (since_dir != 32'd0 || flush_pend) ? S_DIR : S_FULL;
            default:    next = S_ERROR;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cmd_sent <= 1'b0;
            flush_pend <= 1'b0;
            bps <= '0;
            rsvd <= '0;
            sig <= '0;
            spc <= '0;
            num_fats <= '0;
            fat_len <= '0;
            root <= '0;
            data_base <= '0;
            data_count <= '0;
            since_dir <= '0;
            file_length <= '0;
        end else begin
            state <= next;
            cmd_sent <= busy && next == state;
            flush_pend <= flush || (flush_pend && !dir_done);
            if (state == S_READ_BPB && rd_en) begin
                case (rd_addr)
                    9'h00B: bps[7:0] <= rd_byte;
                    9'h00C: bps[15:8] <= rd_byte;
                    9'h00D: spc <= rd_byte;
                    9'h00E: rsvd[7:0] <= rd_byte;
                    9'h00F: rsvd[15:8] <= rd_byte;
                    9'h010: num_fats <= rd_byte;
                    9'h024: fat_len[7:0] <= rd_byte;
                    9'h025: fat_len[15:8] <= rd_byte;
                    9'h026: fat_len[23:16] <= rd_byte;
                    9'h027: fat_len[31:24] <= rd_byte;
                    9'h1FE: sig[7:0] <= rd_byte;
                    9'h1FF: sig[15:8] <= rd_byte;
                    default: ;
                endcase
            end
            if (state == S_CALC) begin
                root <= root_calc;
                data_base <= root_calc + {24'b0, spc};
            end
            if (data_done) begin
                data_count <= data_count + 32'd1;
                file_length <= file_length + 32'd512;
                since_dir <= since_dir + 32'd1;
            end
            if (dir_done) since_dir <= '0;
        end
    end
endmodule

// File: tb/tb_fat32_write_sequencer.sv
// tb_fat32_write_sequencer: BPB vector table plus directed sequences for rewrite cadence, cap, threshold, flush and reset.
module tb_fat32_write_sequencer;
    logic clk = 1'b0;
    initial forever #5 clk = ~clk;
    logic rst, card_ready, rd_start, rd_done_m, stray_rd, rd_en, wr_start, wr_src, wr_done_m, stray_wr, flush, error;
    logic [31:0] rd_sector, wr_sector, file_first_cluster, file_length;
    logic [8:0] rd_addr;
    logic [7:0] rd_byte;
    logic [10:0] fifo_count;
    logic [2:0] state_o;
    logic rd_done_i, wr_done_i;
    assign rd_done_i = rd_done_m | stray_rd;
    assign wr_done_i = wr_done_m | stray_wr;

    fat32_write_sequencer #(.DIR_UPDATE_INTERVAL(2), .MAX_SECTORS(3), .BLOCK_BYTES(512)) dut (
        .clk(clk), .rst(rst), .card_ready(card_ready),
        .rd_start(rd_start), .rd_sector(rd_sector), .rd_done(rd_done_i),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_byte(rd_byte),
        .wr_start(wr_start), .wr_sector(wr_sector), .wr_src(wr_src), .wr_done(wr_done_i),
        .fifo_count(fifo_count), .flush(flush),
        .file_first_cluster(file_first_cluster), .file_length(file_length),
        .state_o(state_o), .error(error)
    );

    typedef struct {
        logic [15:0] sig, bps;
        logic [7:0] spc, nf;
        logic [15:0] rsvd;
        logic [31:0] fl;
        logic err;
        logic [31:0] first;
    } vec_t;
    vec_t v[7];
    logic [7:0] img [512];
    int checks = 0, errors = 0;
    int wr_cnt = 0, rd_cnt = 0, overlap = 0, hold_err = 0, nw = 0;
    logic wbusy = 1'b0;
    logic [31:0] lsec [64];
    logic lsrc [64];
    logic [31:0] llen [64];
    logic [31:0] w_s;
    logic w_src, aborted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build(input vec_t x);
        for (int i = 0; i < 512; i++) img[i] = 8'h00;
        img[11] = x.bps[7:0];  img[12] = x.bps[15:8];
        img[13] = x.spc;
        img[14] = x.rsvd[7:0]; img[15] = x.rsvd[15:8];
        img[16] = x.nf;
        img[36] = x.fl[7:0];   img[37] = x.fl[15:8];
        img[38] = x.fl[23:16]; img[39] = x.fl[31:24];
        img[510] = x.sig[7:0]; img[511] = x.sig[15:8];
    endtask

    task automatic do_reset;
        rst = 1'b1; card_ready = 1'b0; fifo_count = '0; flush = 1'b0;
        tick(3);
        chk("reset state", 32'(state_o), 0);
        chk("reset file_length", file_length, 0);
        chk("reset first_cluster", file_first_cluster, 3);
        chk("reset error", 32'(error), 0);
        rst = 1'b0;
    endtask

    // sector reader model: streams the BPB image, then pulses done
    initial begin
        rd_en = 1'b0; rd_done_m = 1'b0; rd_addr = '0; rd_byte = '0;
        forever begin
            @(negedge clk);
            if (rd_start === 1'b1) begin
                @(negedge clk);
                for (int i = 0; i < 512; i++) begin
                    rd_en = 1'b1; rd_addr = 9'(i); rd_byte = img[i];
                    @(negedge clk);
                end
                rd_en = 1'b0; rd_done_m = 1'b1;
                @(negedge clk);
                rd_done_m = 1'b0;
            end
        end
    end

    // sector writer model: logs each command, checks it stays stable, finishes after 5 cycles
    initial begin
        wr_done_m = 1'b0;
        forever begin
            @(negedge clk);
            if (wr_start === 1'b1 && !rst) begin
                w_s = wr_sector; w_src = wr_src;
                lsec[nw % 64] = w_s; lsrc[nw % 64] = w_src; llen[nw % 64] = file_length;
                nw++; wbusy = 1'b1; aborted = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (rst) aborted = 1'b1;
                    else if (!aborted && (wr_sector !== w_s || wr_src !== w_src || wr_start !== 1'b0)) hold_err++;
                end
                if (!aborted) begin
                    wr_done_m = 1'b1;
                    @(negedge clk);
                    wr_done_m = 1'b0;
                end
                wbusy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (wr_start === 1'b1) wr_cnt++;
        if (rd_start === 1'b1) rd_cnt++;
        if (rd_start === 1'b1 && wr_start === 1'b1) overlap++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base, b;
        logic ok;
        logic [31:0] exp_sec [5];
        logic exp_src [5];
        rst = 1'b1; card_ready = 1'b0; fifo_count = '0; flush = 1'b0; stray_rd = 1'b0; stray_wr = 1'b0;
        v[0] = '{16'hAA55, 16'd512,  8'd8, 8'd2, 16'd32, 32'h3C1,       1'b0, 32'd1962};
        v[1] = '{16'h1234, 16'd512,  8'd8, 8'd2, 16'd32, 32'h3C1,       1'b1, 32'd0};
        v[2] = '{16'hAA55, 16'd1024, 8'd8, 8'd2, 16'd32, 32'h3C1,       1'b1, 32'd0};
        v[3] = '{16'hAA55, 16'd512,  8'd0, 8'd2, 16'd32, 32'h3C1,       1'b1, 32'd0};
        v[4] = '{16'hAA55, 16'd512,  8'd8, 8'd0, 16'd32, 32'h3C1,       1'b1, 32'd0};
        v[5] = '{16'hAA55, 16'd512,  8'd1, 8'd1, 16'd6,  32'd100,       1'b0, 32'd107};
        v[6] = '{16'hAA55, 16'd512,  8'd2, 8'd2, 16'd4,  32'h8000_0010, 1'b0, 32'd38};
        exp_sec = '{32'd1962, 32'd1963, 32'd1954, 32'd1964, 32'd1954};
        exp_src = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        for (int t = 0; t < 7; t++) begin
            build(v[t]);
            do_reset;
            card_ready = 1'b1; fifo_count = 11'd600; base = wr_cnt; ok = 1'b0;
            for (int c = 0; c < 2000 && !ok; c++) begin
                tick(1);
                ok = wr_start | error;
            end
            chk($sformatf("v%0d reached", t), 32'(ok), 1);
            chk($sformatf("v%0d error", t), 32'(error), 32'(v[t].err));
            if (v[t].err) begin
                tick(50);
                chk($sformatf("v%0d no write", t), wr_cnt - base, 0);
                chk($sformatf("v%0d state", t), 32'(state_o), 7);
            end else begin
                chk($sformatf("v%0d wr_sector", t), wr_sector, v[t].first);
                chk($sformatf("v%0d wr_src", t), 32'(wr_src), 0);
            end
        end

        // rewrite cadence and sector cap
        build(v[0]); do_reset;
        card_ready = 1'b1; fifo_count = 11'd600; b = nw; ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            tick(1);
            ok = (nw - b == 5) && !wbusy && state_o == 3'd6;
        end
        chk("cap reached FULL", 32'(ok), 1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("seq%0d sector", i), lsec[(b + i) % 64], exp_sec[i]);
            chk($sformatf("seq%0d src", i), 32'(lsrc[(b + i) % 64]), 32'(exp_src[i]));
        end
        chk("dir1 length", llen[(b + 2) % 64], 1024);
        chk("dir2 length", llen[(b + 4) % 64], 1536);
        chk("full length", file_length, 1536);
        fifo_count = 11'd2047;
        tick(200);
        chk("full no writes", nw - b, 5);
        chk("full state", 32'(state_o), 6);

        // fifo threshold plus stray done pulses
        build(v[0]); do_reset;
        card_ready = 1'b1; fifo_count = 11'd511; ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            tick(1);
            ok = state_o == 3'd3;
        end
        chk("thr reached WAIT", 32'(ok), 1);
        base = wr_cnt;
        for (int c = 0; c < 1000; c++) begin
            stray_wr = (c == 500); stray_rd = (c == 600);
            tick(1);
        end
        stray_wr = 1'b0; stray_rd = 1'b0;
        chk("thr 511 no write", wr_cnt - base, 0);
        chk("thr state WAIT", 32'(state_o), 3);
        fifo_count = 11'd512; ok = 1'b0;
        for (int c = 0; c < 2 && !ok; c++) begin
            tick(1);
            ok = wr_start;
        end
        chk("thr 512 write", 32'(ok), 1);

        // two flush pulses during one data write
        build(v[0]); do_reset;
        card_ready = 1'b1; fifo_count = 11'd600; b = nw; ok = 1'b0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            tick(1);
            ok = wr_start;
        end
        chk("flush first write", 32'(ok), 1);
        fifo_count = '0;
        tick(1); flush = 1'b1; tick(1); flush = 1'b0;
        tick(1); flush = 1'b1; tick(1); flush = 1'b0;
        tick(100);
        chk("flush write count", nw - b, 2);
        chk("flush dir sector", lsec[(b + 1) % 64], 1954);
        chk("flush dir src", 32'(lsrc[(b + 1) % 64]), 1);
        chk("flush dir length", llen[(b + 1) % 64], 512);
        chk("flush back to WAIT", 32'(state_o), 3);

        // reset while a directory write is in flight
        build(v[0]); do_reset;
        card_ready = 1'b1; fifo_count = 11'd600; ok = 1'b0;
        for (int c = 0; c < 3000 && !ok; c++) begin
            tick(1);
            ok = wr_start & wr_src;
        end
        chk("rst dir reached", 32'(ok), 1);
        tick(2);
        rst = 1'b1;
        tick(1);
        chk("rst state", 32'(state_o), 0);
        chk("rst file_length", file_length, 0);
        chk("rst wr_start", 32'(wr_start), 0);
        tick(1);
        rst = 1'b0; card_ready = 1'b0; base = rd_cnt;
        tick(20);
        chk("idle without card", 32'(state_o), 0);
        chk("idle no read", rd_cnt - base, 0);

        chk("command stability", hold_err, 0);
        chk("rd/wr overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
